cc_matrix_scan_comparator: RTL and testbench

- Sequential, parametrised successor of the fixed three-row zero comparator used for game-over and collision decisions.
- Scans NUM_ROWS rows of the playfield matrix, one row per clock, through a row-address/row-data port.
- Two modes: ALLZERO (every row empty) and OVERLAP (any row intersects a reference mask, e.g. the frog sprite).
- Reports a sticky result, a hit count, the first hit row, and a one-cycle done pulse; sits between the matrix registers and the game FSM.

---
 rtl/cc_matrix_scan_comparator.sv | 164 ++++++++++++++++
 tb/tb_cc_matrix_scan_comparator.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_matrix_scan_comparator.sv
// cc_matrix_scan_comparator: sequential row-by-row playfield scanner that
// decides "all rows empty" (ALLZERO) or "any row overlaps a reference mask"
// (OVERLAP). It reads one row per clock via rowAddr/rowData, keeps a sticky
// result, a hit count and the first hit row, and pulses done for one cycle.
// Latency: start at edge 0 -> rows 0..NUM_ROWS-1 on cycles 1..NUM_ROWS ->
// done on cycle NUM_ROWS+1. start is ignored while busy or in DONE (no
// queuing); clear aborts any scan without a done pulse.
//
// Ports:
//   CC_MATRIXSCAN_CLOCK_50         system clock, rising edge
//   CC_MATRIXSCAN_RESET_InHigh     synchronous reset, active-high
//   CC_MATRIXSCAN_start_InHigh     start request (sampled in IDLE only)
//   CC_MATRIXSCAN_clear_InHigh     synchronous abort / clear of results
//   CC_MATRIXSCAN_mode_In          0=ALLZERO, 1=OVERLAP (latched at start)
//   CC_MATRIXSCAN_ref_InBUS        OVERLAP mask (latched at start)
//   CC_MATRIXSCAN_rowData_InBUS    contents of row at rowAddr, same cycle
//   CC_MATRIXSCAN_rowAddr_OutBUS   row being read
//   CC_MATRIXSCAN_busy_OutHigh     scan in progress
//   CC_MATRIXSCAN_done_OutHigh     one-cycle pulse, results valid
//   CC_MATRIXSCAN_result_OutHigh   decision of last completed scan
//   CC_MATRIXSCAN_hitCount_OutBUS  hit rows in last completed scan
//   CC_MATRIXSCAN_firstHit_OutBUS  lowest hit row of last scan (0 if none)
module cc_matrix_scan_comparator #(
  parameter int DATAWIDTH = 8,
  parameter int NUM_ROWS  = 8,
  parameter int ADDRWIDTH = $clog2(NUM_ROWS),
  parameter int CNTWIDTH  = $clog2(NUM_ROWS + 1)
) (
  input  logic                 CC_MATRIXSCAN_CLOCK_50,
  input  logic                 CC_MATRIXSCAN_RESET_InHigh,
  input  logic                 CC_MATRIXSCAN_start_InHigh,
  input  logic                 CC_MATRIXSCAN_clear_InHigh,
  input  logic                 CC_MATRIXSCAN_mode_In,
  input  logic [DATAWIDTH-1:0] CC_MATRIXSCAN_ref_InBUS,
  input  logic [DATAWIDTH-1:0] CC_MATRIXSCAN_rowData_InBUS,
  output logic [ADDRWIDTH-1:0] CC_MATRIXSCAN_rowAddr_OutBUS,
  output logic                 CC_MATRIXSCAN_busy_OutHigh,
  output logic                 CC_MATRIXSCAN_done_OutHigh,
  output logic                 CC_MATRIXSCAN_result_OutHigh,
  output logic [CNTWIDTH-1:0]  CC_MATRIXSCAN_hitCount_OutBUS,
  output logic [ADDRWIDTH-1:0] CC_MATRIXSCAN_firstHit_OutBUS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               stateReg, stateNext;
  logic [ADDRWIDTH-1:0] rowCnt;
  logic                 modeLatched;
  logic [DATAWIDTH-1:0] refLatched;
  logic [CNTWIDTH-1:0]  accCount;
  logic [ADDRWIDTH-1:0] accFirst;
  logic                 accFound;
  logic                 resultReg;
  logic [CNTWIDTH-1:0]  hitCountReg;
  logic [ADDRWIDTH-1:0] firstHitReg;

  logic                 rowHit;
  logic                 lastRow;
  logic [CNTWIDTH-1:0]  countNow;
  logic [ADDRWIDTH-1:0] firstNow;

  // Per-row evaluation, including the row being read this cycle so the final
  // results can be committed on the very edge that enters DONE.
  always_comb begin
    if (modeLatched) begin
      rowHit = |(CC_MATRIXSCAN_rowData_InBUS & refLatched);
    end else begin
      rowHit = (CC_MATRIXSCAN_rowData_InBUS == '0);
    end
    lastRow  = (rowCnt == ADDRWIDTH'(NUM_ROWS - 1));
    countNow = accCount + CNTWIDTH'(rowHit);
    // Once a hit has been recorded, later hits never replace it.
    firstNow = accFound ? accFirst : (rowHit ? rowCnt : '0);
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    stateNext                    = stateReg;
    CC_MATRIXSCAN_busy_OutHigh   = 1'b0;
    CC_MATRIXSCAN_done_OutHigh   = 1'b0;
    CC_MATRIXSCAN_rowAddr_OutBUS = '0;
    unique case (stateReg)
      IDLE: begin
        if (CC_MATRIXSCAN_start_InHigh) stateNext = SCAN;
      end
      SCAN: begin
        CC_MATRIXSCAN_busy_OutHigh   = 1'b1;
        CC_MATRIXSCAN_rowAddr_OutBUS = rowCnt;
        if (lastRow) stateNext = DONE;
      end
      DONE: begin
        CC_MATRIXSCAN_done_OutHigh = 1'b1;
        stateNext                  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Clear beats start and aborts any scan in flight.
    if (CC_MATRIXSCAN_clear_InHigh) stateNext = IDLE;
  end

  always_ff @(posedge CC_MATRIXSCAN_CLOCK_50) begin
    if (CC_MATRIXSCAN_RESET_InHigh) begin
      stateReg    <= IDLE;
      rowCnt      <= '0;
      modeLatched <= 1'b0;
      refLatched  <= '0;
      accCount    <= '0;
      accFirst    <= '0;
      accFound    <= 1'b0;
      resultReg   <= 1'b0;
      hitCountReg <= '0;
      firstHitReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (CC_MATRIXSCAN_clear_InHigh) begin
        rowCnt      <= '0;
        accCount    <= '0;
        accFirst    <= '0;
        accFound    <= 1'b0;
        resultReg   <= 1'b0;
        hitCountReg <= '0;
        firstHitReg <= '0;
      end else begin
        unique case (stateReg)
          IDLE: begin
            if (CC_MATRIXSCAN_start_InHigh) begin
              modeLatched <= CC_MATRIXSCAN_mode_In;
              refLatched  <= CC_MATRIXSCAN_ref_InBUS;
              rowCnt      <= '0;
              accCount    <= '0;
              accFirst    <= '0;
              accFound    <= 1'b0;
            end
          end
          SCAN: begin
            accCount <= countNow;
            accFirst <= firstNow;
            accFound <= accFound | rowHit;
            if (lastRow) begin
              rowCnt      <= '0;
              hitCountReg <= countNow;
              firstHitReg <= firstNow;
              resultReg   <= modeLatched ? (countNow != '0)
                                         : (countNow == CNTWIDTH'(NUM_ROWS));
            end else begin
              rowCnt <= rowCnt + ADDRWIDTH'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign CC_MATRIXSCAN_result_OutHigh  = resultReg;
  assign CC_MATRIXSCAN_hitCount_OutBUS = hitCountReg;
  assign CC_MATRIXSCAN_firstHit_OutBUS = firstHitReg;

endmodule

// File: tb/tb_cc_matrix_scan_comparator.sv
// Bench for cc_matrix_scan_comparator: an 8-row and a 3-row instance share
// clock/reset; a table of scan vectors plus hand-written abort sequences,
// with expected results queued at start and compared on done.
module tb_cc_matrix_scan_comparator;

  localparam int NA = 8;
  localparam int NB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       startIn, clearIn, modeIn;
  logic [7:0] refIn;
  bit         sel;  // 0 = 8-row instance, 1 = 3-row instance

  logic       startA, clearA, startB, clearB;
  logic [7:0] rowDataA, rowDataB;
  logic [2:0] rowAddrA, firstHitA;
  logic [3:0] hitCountA;
  logic       busyA, doneA, resultA;
  logic [1:0] rowAddrB, firstHitB, hitCountB;
  logic       busyB, doneB, resultB;

  logic [7:0] memA [NA];
  logic [7:0] memB [NB];

  assign startA = startIn & ~sel;
  assign clearA = clearIn & ~sel;
  assign startB = startIn & sel;
  assign clearB = clearIn & sel;

  always_comb rowDataA = memA[rowAddrA];
  always_comb rowDataB = (rowAddrB < 2'(NB)) ? memB[rowAddrB] : 8'h00;

  cc_matrix_scan_comparator #(.DATAWIDTH(8), .NUM_ROWS(NA)) dutA (
    .CC_MATRIXSCAN_CLOCK_50       (clk),
    .CC_MATRIXSCAN_RESET_InHigh   (rst),
    .CC_MATRIXSCAN_start_InHigh   (startA),
    .CC_MATRIXSCAN_clear_InHigh   (clearA),
    .CC_MATRIXSCAN_mode_In        (modeIn),
    .CC_MATRIXSCAN_ref_InBUS      (refIn),
    .CC_MATRIXSCAN_rowData_InBUS  (rowDataA),
    .CC_MATRIXSCAN_rowAddr_OutBUS (rowAddrA),
    .CC_MATRIXSCAN_busy_OutHigh   (busyA),
    .CC_MATRIXSCAN_done_OutHigh   (doneA),
    .CC_MATRIXSCAN_result_OutHigh (resultA),
    .CC_MATRIXSCAN_hitCount_OutBUS(hitCountA),
    .CC_MATRIXSCAN_firstHit_OutBUS(firstHitA)
  );

  cc_matrix_scan_comparator #(.DATAWIDTH(8), .NUM_ROWS(NB)) dutB (
    .CC_MATRIXSCAN_CLOCK_50       (clk),
    .CC_MATRIXSCAN_RESET_InHigh   (rst),
    .CC_MATRIXSCAN_start_InHigh   (startB),
    .CC_MATRIXSCAN_clear_InHigh   (clearB),
    .CC_MATRIXSCAN_mode_In        (modeIn),
    .CC_MATRIXSCAN_ref_InBUS      (refIn),
    .CC_MATRIXSCAN_rowData_InBUS  (rowDataB),
    .CC_MATRIXSCAN_rowAddr_OutBUS (rowAddrB),
    .CC_MATRIXSCAN_busy_OutHigh   (busyB),
    .CC_MATRIXSCAN_done_OutHigh   (doneB),
    .CC_MATRIXSCAN_result_OutHigh (resultB),
    .CC_MATRIXSCAN_hitCount_OutBUS(hitCountB),
    .CC_MATRIXSCAN_firstHit_OutBUS(firstHitB)
  );

  // Observation mux onto the selected instance.
  logic       obsBusy, obsDone, obsResult;
  logic [3:0] obsCount;
  logic [2:0] obsAddr, obsFirst;
  always_comb begin
    obsBusy   = sel ? busyB   : busyA;
    obsDone   = sel ? doneB   : doneA;
    obsResult = sel ? resultB : resultA;
    obsCount  = sel ? {2'b00, hitCountB} : hitCountA;
    obsAddr   = sel ? {1'b0, rowAddrB}   : rowAddrA;
    obsFirst  = sel ? {1'b0, firstHitB}  : firstHitA;
  end

  typedef struct {
    bit r;
    int cnt;
    int first;
  } exp_t;

  typedef struct {
    bit          mode;
    logic [7:0]  refm;
    logic [63:0] rows;  // row i in rows[i*8 +: 8]
    bit          expR;
    int          expCnt;
    int          expFirst;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[7];
  int   nChecks = 0;
  int   nPass   = 0;

  task automatic chk(input string name, input int act, input int req);
    nChecks++;
    if (act == req) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadA(input vec_t v);
    for (int i = 0; i < NA; i++) memA[i] = v.rows[i*8 +: 8];
    modeIn = v.mode;
    refIn  = v.refm;
  endtask

  // One complete scan on the selected instance. perturb: change mode/ref
  // mid-scan and pulse start during SCAN and during DONE.
  task automatic runScan(input string tag, input exp_t e, input bit perturb);
    int   n;
    int   cyc;
    int   busyCnt;
    int   extra;
    bit   seen;
    exp_t got;
    n = sel ? NB : NA;
    startIn = 1'b1;
    sbq.push_back(e);
    tick();
    startIn = 1'b0;
    cyc = 1;
    busyCnt = 0;
    seen = 1'b0;
    while (!seen && cyc <= 3 * n) begin
      if (obsDone) begin
        seen = 1'b1;
        chk({tag, " doneCycle"}, cyc, n + 1);
        chk({tag, " busyCycles"}, busyCnt, n);
        if (sbq.size() == 0) begin
          nChecks++;
          $display("FAIL %s scoreboard: got done, expected none", tag);
        end else begin
          got = sbq.pop_front();
          chk({tag, " result"}, obsResult, got.r);
          chk({tag, " hitCount"}, obsCount, got.cnt);
          chk({tag, " firstHit"}, obsFirst, got.first);
        end
        if (perturb) startIn = 1'b1;
      end else begin
        if (obsBusy) begin
          busyCnt++;
          chk({tag, " rowAddr"}, obsAddr, cyc - 1);
        end
        if (perturb && cyc == 2) begin
          refIn  = 8'h00;
          modeIn = ~modeIn;
        end
        if (perturb && cyc == 3) startIn = 1'b1;
        if (perturb && cyc == 4) startIn = 1'b0;
        tick();
        cyc++;
      end
    end
    if (!seen) begin
      nChecks++;
      $display("FAIL %s timeout: got no done, expected done by cycle %0d", tag, n + 1);
    end
    tick();
    startIn = 1'b0;
    extra = 0;
    for (int i = 0; i < n + 2; i++) begin
      if (obsDone || obsBusy) extra++;
      tick();
    end
    chk({tag, " idleAfter"}, extra, 0);
  endtask

  task automatic waitAddr(input int row);
    int guard;
    guard = 0;
    while (!(obsBusy && obsAddr == 3'(row)) && guard < 32) begin
      tick();
      guard++;
    end
    chk("waitAddr reached", int'(obsAddr), row);
  endtask

  task automatic checkZeroed(input string tag);
    chk({tag, " busy"}, obsBusy, 0);
    chk({tag, " done"}, obsDone, 0);
    chk({tag, " rowAddr"}, obsAddr, 0);
    chk({tag, " result"}, obsResult, 0);
    chk({tag, " hitCount"}, obsCount, 0);
    chk({tag, " firstHit"}, obsFirst, 0);
  endtask

  task automatic noDone(input string tag, input int cycles);
    int dn;
    dn = 0;
    for (int i = 0; i < cycles; i++) begin
      if (obsDone || obsBusy) dn++;
      tick();
    end
    chk({tag, " noDone"}, dn, 0);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{1'b0, 8'h00, 64'h0000_0000_0000_0000, 1'b1, 8, 0};
    vecs[1] = '{1'b0, 8'h00, 64'h0000_0000_0001_0000, 1'b0, 7, 0};
    vecs[2] = '{1'b0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0};
    vecs[3] = '{1'b1, 8'h18, 64'hFF81_0881_8181_8181, 1'b1, 2, 5};
    vecs[4] = '{1'b1, 8'h00, 64'hFF81_0881_8181_8181, 1'b0, 0, 0};
    vecs[5] = '{1'b1, 8'hFF, 64'h0101_0101_0101_0100, 1'b1, 7, 1};
    vecs[6] = '{1'b0, 8'h00, 64'h0000_0101_0101_0101, 1'b0, 2, 6};

    sel = 1'b0;
    rst = 1'b1;
    startIn = 1'b0;
    clearIn = 1'b0;
    modeIn = 1'b0;
    refIn = 8'h00;
    for (int i = 0; i < NA; i++) memA[i] = 8'h00;
    for (int i = 0; i < NB; i++) memB[i] = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    checkZeroed("resetA");
    sel = 1'b1;
    checkZeroed("resetB");
    sel = 1'b0;

    for (int k = 0; k < 7; k++) begin
      loadA(vecs[k]);
      e = '{vecs[k].expR, vecs[k].expCnt, vecs[k].expFirst};
      runScan($sformatf("vec%0d", k), e, 1'b0);
    end

    // Mid-scan mode/ref changes and start pulses in SCAN/DONE are ignored.
    loadA(vecs[3]);
    e = '{1'b1, 2, 5};
    runScan("perturb", e, 1'b1);

    // Clear at row 4 aborts the scan and zeroes results.
    loadA(vecs[6]);
    startIn = 1'b1;
    tick();
    startIn = 1'b0;
    waitAddr(4);
    clearIn = 1'b1;
    tick();
    clearIn = 1'b0;
    checkZeroed("clearRow4");
    noDone("clearRow4", NA + 3);

    // Clear and start together in IDLE: clear wins.
    loadA(vecs[0]);
    e = '{1'b1, 8, 0};
    runScan("preClrStart", e, 1'b0);
    startIn = 1'b1;
    clearIn = 1'b1;
    tick();
    startIn = 1'b0;
    clearIn = 1'b0;
    checkZeroed("clrStart");
    noDone("clrStart", 3);

    // Reset at row 3 of a scan.
    loadA(vecs[3]);
    e = '{1'b1, 2, 5};
    runScan("preReset", e, 1'b0);
    startIn = 1'b1;
    tick();
    startIn = 1'b0;
    waitAddr(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkZeroed("resetRow3");
    noDone("resetRow3", NA + 3);

    // Three-row instance.
    sel = 1'b1;
    modeIn = 1'b0;
    refIn = 8'h00;
    memB[0] = 8'h00; memB[1] = 8'h00; memB[2] = 8'h00;
    e = '{1'b1, 3, 0};
    runScan("n3 allzero", e, 1'b0);
    memB[1] = 8'h10;
    e = '{1'b0, 2, 0};
    runScan("n3 onebusy", e, 1'b0);
    memB[0] = 8'h01; memB[1] = 8'h00; memB[2] = 8'h00;
    e = '{1'b0, 2, 1};
    runScan("n3 firstlate", e, 1'b0);

    chk("scoreboard empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
